// File: rtl/mac_accum_4b_if.sv
// rtl/mac_accum_4b_if.sv - operand-in / result-out handshake bundle for mac_accum_4b
interface mac_accum_4b_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_x;
  logic [3:0]       in_y;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/mac_accum_4b.sv
// rtl/mac_accum_4b.sv - 4x4 tree multiplier feeding a TERMS-deep dot-product accumulator; define MAC_SAT_EN for saturating results
module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);
  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] s01, s23;

  // Partial products reduced by a two-level adder tree
  always_comb begin
    pp0 = y[0] ? {4'b0, x}       : 8'd0;
    pp1 = y[1] ? {3'b0, x, 1'b0} : 8'd0;
    pp2 = y[2] ? {2'b0, x, 2'b0} : 8'd0;
    pp3 = y[3] ? {1'b0, x, 3'b0} : 8'd0;
    s01 = pp0 + pp1;
    s23 = pp2 + pp3;
    o   = s01 + s23;
  end
endmodule

module mac_accum_4b #(
  parameter int TERMS = 4,
  parameter int ACC_W = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_accum_4b_if.slave bus
);
  localparam int             CW   = $clog2(TERMS);
  localparam logic [CW-1:0] LAST = CW'(TERMS - 1);

  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [7:0]       prod;
  logic [CW-1:0]    cnt;
  logic [7:0]       p_q;
  logic             p_v, p_first, p_last;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             ovf_acc, ovf_nxt;
  logic [ACC_W:0]   sum;
  logic             out_valid_q, out_ovf_q;
  logic [ACC_W-1:0] out_acc_q;

  main u_mul (.x(bus.in_x), .y(bus.in_y), .o(prod));

  // Accept only in ACC, so in_ready comes straight from a register
  assign bus.in_ready  = (state == ACC);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ovf   = out_ovf_q;

  // Input FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  // Input FSM next state: last term -> one drain cycle -> hold until result taken
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && cnt == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (out_valid_q && bus.out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Term counter, idle cycles leave it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (accept) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // Stage P: register product with first/last-term markers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      p_v     <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
    end else if (accept) begin
      p_q     <= prod;
      p_v     <= 1'b1;
      p_first <= (cnt == '0);
      p_last  <= (cnt == LAST);
    end else begin
      p_v     <= 1'b0;
    end
  end

  // Next accumulator value; the first term restarts the sum and the sticky overflow
  always_comb begin
    sum     = (p_first ? '0 : {1'b0, acc}) + {{(ACC_W + 1 - 8){1'b0}}, p_q};
    ovf_nxt = (p_first ? 1'b0 : ovf_acc) | sum[ACC_W];
`ifdef MAC_SAT_EN
    acc_nxt = ovf_nxt ? '1 : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  // Stage A: commit accumulator whenever a product is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (p_v) begin
      acc     <= acc_nxt;
      ovf_acc <= ovf_nxt;
    end
  end

  // Result register: loaded from the final term, held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (p_v && p_last) begin
      out_valid_q <= 1'b1;
      out_acc_q   <= acc_nxt;
      out_ovf_q   <= ovf_nxt;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_accum_4b.sv
// tb/tb_mac_accum_4b.sv - bench for mac_accum_4b (default and TERMS=2/ACC_W=8 instances)
module tb_mac_accum_4b;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [3:0] drv_x, drv_y;
  logic drv_v, sel, rdy_a, rdy_b, drv_rdy;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

`ifdef MAC_SAT_EN
  localparam int OVF_ACC = 255;
`else
  localparam int OVF_ACC = 194;
`endif

  mac_accum_4b_if #(.ACC_W(12)) ifa ();
  mac_accum_4b_if #(.ACC_W(8))  ifb ();

  mac_accum_4b #(.TERMS(4), .ACC_W(12)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  mac_accum_4b #(.TERMS(2), .ACC_W(8))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  assign ifa.in_x      = drv_x;
  assign ifa.in_y      = drv_y;
  assign ifb.in_x      = drv_x;
  assign ifb.in_y      = drv_y;
  assign ifa.in_valid  = drv_v & ~sel;
  assign ifb.in_valid  = drv_v & sel;
  assign ifa.out_ready = rdy_a;
  assign ifb.out_ready = rdy_b;
  assign drv_rdy       = sel ? ifb.in_ready : ifa.in_ready;

  typedef struct {
    logic [11:0] acc;
    logic        ovf;
  } exp_t;

  typedef struct {
    int x[4];
    int y[4];
    int acc;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  vec_t vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard: compare each result at its handshake
  always @(negedge clk) begin
    if (rst_n && ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) fail_now("a_unexpected_result");
      else begin
        ea = qa.pop_front();
        chk("a_out_acc", 32'(ifa.out_acc), 32'(ea.acc));
        chk("a_out_ovf", 32'(ifa.out_ovf), 32'(ea.ovf));
      end
    end
    if (rst_n && ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) fail_now("b_unexpected_result");
      else begin
        eb = qb.pop_front();
        chk("b_out_acc", 32'(ifb.out_acc), 32'(eb.acc));
        chk("b_out_ovf", 32'(ifb.out_ovf), 32'(eb.ovf));
      end
    end
  end

  task automatic send_term(input int x, input int y);
    int n;
    n = 0;
    drv_x = 4'(x);
    drv_y = 4'(y);
    drv_v = 1'b1;
    @(negedge clk);
    while (!drv_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    drv_v = 1'b0;
  endtask

  task automatic push_exp(input bit s, input int acc, input bit ovf);
    exp_t e;
    e.acc = 12'(acc);
    e.ovf = ovf;
    if (s) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) fail_now("drain_timeout");
  endtask

  task automatic wait_out_a();
    int n;
    n = 0;
    while (!ifa.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) fail_now("out_valid_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, g;
    vecs[0] = '{x: '{3, 15, 0, 7},   y: '{5, 15, 9, 2},   acc: 254};
    vecs[1] = '{x: '{15, 15, 15, 15}, y: '{15, 15, 15, 15}, acc: 900};
    vecs[2] = '{x: '{0, 0, 15, 0},   y: '{0, 15, 0, 0},   acc: 0};
    vecs[3] = '{x: '{1, 1, 1, 1},    y: '{2, 2, 2, 2},    acc: 8};
    vecs[4] = '{x: '{9, 4, 13, 2},   y: '{7, 11, 6, 2},   acc: 189};

    drv_v = 0; sel = 0; rdy_a = 1; rdy_b = 1; drv_x = 0; drv_y = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_a_out_valid", 32'(ifa.out_valid), 0);
    chk("rst_a_out_acc", 32'(ifa.out_acc), 0);
    chk("rst_a_out_ovf", 32'(ifa.out_ovf), 0);
    chk("rst_a_in_ready", 32'(ifa.in_ready), 1);
    chk("rst_b_in_ready", 32'(ifb.in_ready), 1);

    // Basic sum: latency and throughput
    sel = 0;
    push_exp(0, 254, 0);
    c0 = cyc;
    send_term(3, 5); send_term(15, 15); send_term(0, 9); send_term(7, 2);
    chk("basic_accept_cycles", 32'(cyc - c0), 4);
    chk("basic_valid_at_E", 32'(ifa.out_valid), 0);
    chk("basic_ready_at_E", 32'(ifa.in_ready), 0);
    @(posedge clk); #1;
    chk("basic_valid_at_E1", 32'(ifa.out_valid), 1);
    chk("basic_ready_at_E1", 32'(ifa.in_ready), 0);
    chk("basic_acc_at_E1", 32'(ifa.out_acc), 254);
    @(posedge clk); #1;
    chk("basic_valid_at_E2", 32'(ifa.out_valid), 0);
    chk("basic_ready_at_E2", 32'(ifa.in_ready), 1);

    // Backpressure: result held, no new accepts
    rdy_a = 0;
    push_exp(0, 254, 0);
    send_term(3, 5); send_term(15, 15); send_term(0, 9); send_term(7, 2);
    wait_out_a();
    drv_x = 1; drv_y = 1; drv_v = 1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_held", 32'(ifa.out_valid), 1);
      chk("bp_acc_held", 32'(ifa.out_acc), 254);
      chk("bp_ready_low", 32'(ifa.in_ready), 0);
      @(posedge clk); #1;
    end
    drv_v = 0;
    rdy_a = 1;
    @(posedge clk); #1;
    chk("bp_valid_cleared", 32'(ifa.out_valid), 0);
    chk("bp_ready_back", 32'(ifa.in_ready), 1);
    chk("bp_queue_empty", 32'(qa.size()), 0);

    // Table vectors with random idle gaps between terms
    for (int i = 0; i < 5; i++) begin
      push_exp(0, vecs[i].acc, 0);
      for (int t = 0; t < 4; t++) begin
        send_term(vecs[i].x[t], vecs[i].y[t]);
        g = int'($urandom_range(3, 0));
        if (t < 3 && g > 0) begin
          repeat (g) @(posedge clk);
          #1;
        end
      end
      drain();
    end

    // Overflow on the narrow instance, then a clean dot product
    sel = 1;
    push_exp(1, OVF_ACC, 1);
    send_term(15, 15); send_term(15, 15);
    drain();
    push_exp(1, 2, 0);
    send_term(1, 1); send_term(1, 1);
    drain();

    // Reset mid dot product: partial sum discarded
    sel = 0;
    send_term(1, 1); send_term(2, 2);
    #3;
    rst_n = 0;
    #1;
    chk("midrst_a_valid", 32'(ifa.out_valid), 0);
    chk("midrst_a_acc", 32'(ifa.out_acc), 0);
    chk("midrst_a_ovf", 32'(ifa.out_ovf), 0);
    chk("midrst_b_acc", 32'(ifb.out_acc), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("midrst_ready", 32'(ifa.in_ready), 1);
    push_exp(0, 8, 0);
    send_term(1, 2); send_term(1, 2); send_term(1, 2); send_term(1, 2);
    drain();

    // Reset while a result is held
    rdy_a = 0;
    send_term(3, 3); send_term(3, 3); send_term(3, 3); send_term(3, 3);
    wait_out_a();
    chk("holdrst_acc_before", 32'(ifa.out_acc), 36);
    #2;
    rst_n = 0;
    #1;
    chk("holdrst_valid", 32'(ifa.out_valid), 0);
    chk("holdrst_acc", 32'(ifa.out_acc), 0);
    @(negedge clk);
    rst_n = 1;
    rdy_a = 1;
    @(posedge clk); #1;

    // Exhaustive multiplier sweep through the TERMS=2 instance
    sel = 1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        push_exp(1, x * y, 0);
        send_term(x, y);
        send_term(0, 0);
      end
    end
    drain();

    chk("queues_empty", 32'(qa.size() + qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
